// File: rtl/alu_pipe_ctrl_if.sv
// Operand/result bundle for alu_pipe_ctrl: master drives operands and controls,
// slave returns the registered result and status flags.
interface alu_pipe_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 4
);
    localparam int unsigned RW = 2 * DW;

    logic          CE;
    logic          MODE;
    logic [CW-1:0] CMD;
    logic [1:0]    INP_VALID;
    logic [DW-1:0] OPA;
    logic [DW-1:0] OPB;
    logic          CIN;
    logic          BUSY;
    logic          RES_VALID;
    logic [RW-1:0] RES;
    logic          COUT;
    logic          OFLOW;
    logic          G;
    logic          E;
    logic          L;
    logic          ERR;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  BUSY, RES_VALID, RES, COUT, OFLOW, G, E, L, ERR
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output BUSY, RES_VALID, RES, COUT, OFLOW, G, E, L, ERR
    );
endinterface

// File: rtl/alu_pipe_ctrl.sv
// Two-operand ALU with split operand capture, operand timeout and a 2-stage multiply.
// Define ALU_SIGNED_EN to enable signed add/subtract on arithmetic CMD 11/12.
module alu_pipe_ctrl #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input logic            CLK,
    input logic            RST,
    alu_pipe_ctrl_if.slave io_bus
);
    localparam int unsigned RW   = 2 * DW;
    localparam int unsigned AW   = $clog2(DW);
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StWaitA, StWaitB, StExec, StMul2} state_t;

    state_t          r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0]   r_a, w_a_nxt, r_b, w_b_nxt;
    logic            r_mode, w_mode_nxt, r_cin, w_cin_nxt;
    logic [CW-1:0]   r_cmd, w_cmd_nxt;
    logic [DW:0]     r_mul_a, w_mul_a_nxt, r_mul_b, w_mul_b_nxt;
    logic            r_busy, w_busy_nxt, r_valid, w_valid_nxt;
    logic [RW-1:0]   r_res, w_res_nxt;
    logic            r_cout, w_cout_nxt, r_oflow, w_oflow_nxt;
    logic            r_g, w_g_nxt, r_e, w_e_nxt, r_l, w_l_nxt, r_err, w_err_nxt;

    logic [DW-1:0]   w_as_x, w_as_y;
    logic            w_as_c, w_as_sub;
    logic [DW+1:0]   w_addsub;
    logic [DW-1:0]   w_lres;
    logic [2*DW-1:0] w_rol_dbl, w_ror_dbl;
    logic            w_rot_bad;
    logic [RW-1:0]   w_alu_res;
    logic            w_alu_cout, w_alu_oflow, w_alu_g, w_alu_e, w_alu_l, w_alu_err;
    logic            w_alu_mul;
    logic [DW:0]     w_mula_pre, w_mulb_pre;
    logic [RW-1:0]   w_prod;
`ifdef ALU_SIGNED_EN
    logic [DW:0]     w_sadd, w_ssub;
`endif

    // Shared adder/subtractor; subtract results keep the borrow in bit DW+1
    always_comb begin
        w_as_x   = r_a;
        w_as_y   = r_b;
        w_as_c   = 1'b0;
        w_as_sub = 1'b0;
        case (r_cmd)
            CW'(1): w_as_sub = 1'b1;
            CW'(2): w_as_c = r_cin;
            CW'(3): begin w_as_sub = 1'b1; w_as_c = r_cin; end
            CW'(4): begin w_as_y = '0; w_as_c = 1'b1; end
            CW'(5): begin w_as_y = '0; w_as_c = 1'b1; w_as_sub = 1'b1; end
            CW'(6): begin w_as_x = r_b; w_as_y = '0; w_as_c = 1'b1; end
            CW'(7): begin w_as_x = r_b; w_as_y = '0; w_as_c = 1'b1; w_as_sub = 1'b1; end
            default: ;
        endcase
    end

    assign w_addsub = w_as_sub
        ? ({2'b00, w_as_x} - {2'b00, w_as_y} - {{(DW + 1){1'b0}}, w_as_c})
        : ({2'b00, w_as_x} + {2'b00, w_as_y} + {{(DW + 1){1'b0}}, w_as_c});

    assign w_rol_dbl = {r_a, r_a} << r_b[AW-1:0];
    assign w_ror_dbl = {r_a, r_a} >> r_b[AW-1:0];
    assign w_rot_bad = |r_b[DW-1:AW];

    assign w_mula_pre = (r_cmd == CW'(9)) ? ({1'b0, r_a} + {{DW{1'b0}}, 1'b1}) : {r_a, 1'b0};
    assign w_mulb_pre = (r_cmd == CW'(9)) ? ({1'b0, r_b} + {{DW{1'b0}}, 1'b1}) : {1'b0, r_b};
    assign w_prod     = RW'({{(DW + 1){1'b0}}, r_mul_a} * {{(DW + 1){1'b0}}, r_mul_b});

`ifdef ALU_SIGNED_EN
    assign w_sadd = {r_a[DW-1], r_a} + {r_b[DW-1], r_b};
    assign w_ssub = {r_a[DW-1], r_a} - {r_b[DW-1], r_b};
`endif

    always_comb begin
        w_alu_res   = '0;
        w_alu_cout  = 1'b0;
        w_alu_oflow = 1'b0;
        w_alu_g     = 1'b0;
        w_alu_e     = 1'b0;
        w_alu_l     = 1'b0;
        w_alu_err   = 1'b0;
        w_alu_mul   = 1'b0;
        w_lres      = '0;
        if (r_mode) begin
            case (r_cmd)
                CW'(0), CW'(2), CW'(4), CW'(6): begin
                    w_alu_res  = RW'(w_addsub[DW:0]);
                    w_alu_cout = w_addsub[DW];
                end
                CW'(1), CW'(3), CW'(5), CW'(7): begin
                    w_alu_res   = RW'(w_addsub[DW:0]);
                    w_alu_oflow = w_addsub[DW+1];
                end
                CW'(8): begin
                    w_alu_g = (r_a > r_b);
                    w_alu_e = (r_a == r_b);
                    w_alu_l = (r_a < r_b);
                end
                CW'(9), CW'(10): w_alu_mul = 1'b1;
`ifdef ALU_SIGNED_EN
                CW'(11): begin
                    w_alu_res   = {{(RW - DW - 1){w_sadd[DW]}}, w_sadd};
                    w_alu_oflow = w_sadd[DW] ^ w_sadd[DW-1];
                end
                CW'(12): begin
                    w_alu_res   = {{(RW - DW - 1){w_ssub[DW]}}, w_ssub};
                    w_alu_oflow = w_ssub[DW] ^ w_ssub[DW-1];
                end
`endif
                default: w_alu_err = 1'b1;
            endcase
        end else begin
            case (r_cmd)
                CW'(0):  w_lres = r_a & r_b;
                CW'(1):  w_lres = ~(r_a & r_b);
                CW'(2):  w_lres = r_a | r_b;
                CW'(3):  w_lres = ~(r_a | r_b);
                CW'(4):  w_lres = r_a ^ r_b;
                CW'(5):  w_lres = ~(r_a ^ r_b);
                CW'(6):  w_lres = ~r_a;
                CW'(7):  w_lres = ~r_b;
                CW'(8):  w_lres = r_a >> 1;
                CW'(9):  w_lres = r_a << 1;
                CW'(10): w_lres = r_b >> 1;
                CW'(11): w_lres = r_b << 1;
                CW'(12): if (w_rot_bad) w_alu_err = 1'b1; else w_lres = w_rol_dbl[2*DW-1:DW];
                CW'(13): if (w_rot_bad) w_alu_err = 1'b1; else w_lres = w_ror_dbl[DW-1:0];
                default: w_alu_err = 1'b1;
            endcase
            w_alu_res = RW'(w_lres);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_mode_nxt  = r_mode;
        w_cmd_nxt   = r_cmd;
        w_cin_nxt   = r_cin;
        w_mul_a_nxt = r_mul_a;
        w_mul_b_nxt = r_mul_b;
        w_busy_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_res_nxt   = r_res;
        w_cout_nxt  = r_cout;
        w_oflow_nxt = r_oflow;
        w_g_nxt     = r_g;
        w_e_nxt     = r_e;
        w_l_nxt     = r_l;
        w_err_nxt   = r_err;
        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (io_bus.INP_VALID[0]) w_a_nxt = io_bus.OPA;
                if (io_bus.INP_VALID[1]) w_b_nxt = io_bus.OPB;
                case (io_bus.INP_VALID)
                    2'b11:   w_state_nxt = StExec;
                    2'b01:   w_state_nxt = StWaitB;
                    2'b10:   w_state_nxt = StWaitA;
                    default: ;
                endcase
            end
            StWaitA, StWaitB: begin
                if (io_bus.INP_VALID[0]) w_a_nxt = io_bus.OPA;
                if (io_bus.INP_VALID[1]) w_b_nxt = io_bus.OPB;
                if (io_bus.INP_VALID == 2'b11 ||
                    (r_state == StWaitB && io_bus.INP_VALID[1]) ||
                    (r_state == StWaitA && io_bus.INP_VALID[0])) begin
                    w_state_nxt = StExec;
                    w_cnt_nxt   = '0;
                end else if (io_bus.INP_VALID != 2'b00) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                    // Partial operand is dropped and the timeout is reported as a result
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = '0;
                    w_a_nxt     = '0;
                    w_b_nxt     = '0;
                    w_valid_nxt = 1'b1;
                    w_res_nxt   = '0;
                    w_cout_nxt  = 1'b0;
                    w_oflow_nxt = 1'b0;
                    w_g_nxt     = 1'b0;
                    w_e_nxt     = 1'b0;
                    w_l_nxt     = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNTW'(1);
                end
            end
            StExec: begin
                if (w_alu_mul) begin
                    w_state_nxt = StMul2;
                    w_busy_nxt  = 1'b1;
                    w_mul_a_nxt = w_mula_pre;
                    w_mul_b_nxt = w_mulb_pre;
                end else begin
                    w_state_nxt = StIdle;
                    w_valid_nxt = 1'b1;
                    w_res_nxt   = w_alu_res;
                    w_cout_nxt  = w_alu_cout;
                    w_oflow_nxt = w_alu_oflow;
                    w_g_nxt     = w_alu_g;
                    w_e_nxt     = w_alu_e;
                    w_l_nxt     = w_alu_l;
                    w_err_nxt   = w_alu_err;
                end
            end
            StMul2: begin
                w_state_nxt = StIdle;
                w_valid_nxt = 1'b1;
                w_res_nxt   = w_prod;
                w_cout_nxt  = 1'b0;
                w_oflow_nxt = 1'b0;
                w_g_nxt     = 1'b0;
                w_e_nxt     = 1'b0;
                w_l_nxt     = 1'b0;
                w_err_nxt   = 1'b0;
            end
            default: w_state_nxt = StIdle;
        endcase
        // Controls are latched only on the edge that completes the operand pair
        if (w_state_nxt == StExec) begin
            w_mode_nxt = io_bus.MODE;
            w_cmd_nxt  = io_bus.CMD;
            w_cin_nxt  = io_bus.CIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mode  <= 1'b0;
            r_cmd   <= '0;
            r_cin   <= 1'b0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_g     <= 1'b0;
            r_e     <= 1'b0;
            r_l     <= 1'b0;
            r_err   <= 1'b0;
        end else if (io_bus.CE) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_mode  <= w_mode_nxt;
            r_cmd   <= w_cmd_nxt;
            r_cin   <= w_cin_nxt;
            r_mul_a <= w_mul_a_nxt;
            r_mul_b <= w_mul_b_nxt;
            r_busy  <= w_busy_nxt;
            r_valid <= w_valid_nxt;
            r_res   <= w_res_nxt;
            r_cout  <= w_cout_nxt;
            r_oflow <= w_oflow_nxt;
            r_g     <= w_g_nxt;
            r_e     <= w_e_nxt;
            r_l     <= w_l_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign io_bus.BUSY      = r_busy;
    assign io_bus.RES_VALID = r_valid;
    assign io_bus.RES       = r_res;
    assign io_bus.COUT      = r_cout;
    assign io_bus.OFLOW     = r_oflow;
    assign io_bus.G         = r_g;
    assign io_bus.E         = r_e;
    assign io_bus.L         = r_l;
    assign io_bus.ERR       = r_err;
endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// Directed-vector bench for alu_pipe_ctrl (DW=8, TIMEOUT=16).
module tb_alu_pipe_ctrl;
    localparam int unsigned DW      = 8;
    localparam int unsigned CW      = 4;
    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst;
    int unsigned vecs;
    int unsigned fails;

    alu_pipe_ctrl_if #(.DW(DW), .CW(CW)) bus ();

    alu_pipe_ctrl #(.DW(DW), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .CLK    (clk),
        .RST    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin);
        bus.MODE      = mode;
        bus.CMD       = cmd;
        bus.OPA       = a;
        bus.OPB       = b;
        bus.CIN       = cin;
        bus.INP_VALID = 2'b11;
        step();
        bus.INP_VALID = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vecs++;
        if (bus.RES !== 16'h0000) begin
            fails++; $display("FAIL reset_res: got %0h want 0", bus.RES);
        end
        vecs++;
        if ({bus.BUSY, bus.RES_VALID, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} !== 8'h00)
        begin
            fails++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {bus.BUSY, bus.RES_VALID, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR});
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        issue(1'b1, 4'd0, 8'd200, 8'd100, 1'b0);
        vecs++;
        if (bus.RES_VALID !== 1'b0) begin
            fails++; $display("FAIL add_early_valid: got %b want 0", bus.RES_VALID);
        end
        step();
        vecs++;
        if (bus.RES !== 16'd300) begin
            fails++; $display("FAIL add_res: got %0d want 300", bus.RES);
        end
        vecs++;
        if ({bus.RES_VALID, bus.COUT, bus.ERR} !== 3'b110) begin
            fails++; $display("FAIL add_flags: got %b want 110", {bus.RES_VALID, bus.COUT, bus.ERR});
        end
        step();
        vecs++;
        if ({bus.RES_VALID, bus.RES} !== {1'b0, 16'd300}) begin
            fails++; $display("FAIL add_hold: got %b/%0d want 0/300", bus.RES_VALID, bus.RES);
        end
        issue(1'b1, 4'd2, 8'd255, 8'd0, 1'b1);
        step();
        vecs++;
        if ({bus.RES, bus.COUT} !== {16'h0100, 1'b1}) begin
            fails++; $display("FAIL addc_res: got %0h/%b want 100/1", bus.RES, bus.COUT);
        end
    endtask

    task automatic test_sub();
        issue(1'b1, 4'd1, 8'd5, 8'd7, 1'b0);
        step();
        vecs++;
        if ({bus.RES, bus.OFLOW, bus.COUT} !== {16'h01FE, 1'b1, 1'b0}) begin
            fails++; $display("FAIL sub_borrow: got %0h/%b/%b want 1fe/1/0", bus.RES, bus.OFLOW, bus.COUT);
        end
        issue(1'b1, 4'd3, 8'd10, 8'd3, 1'b1);
        step();
        vecs++;
        if ({bus.RES, bus.OFLOW} !== {16'd6, 1'b0}) begin
            fails++; $display("FAIL subc_res: got %0d/%b want 6/0", bus.RES, bus.OFLOW);
        end
    endtask

    task automatic test_mul_split();
        bus.CMD       = 4'd0;
        bus.OPA       = 8'd5;
        bus.INP_VALID = 2'b01;
        step();
        bus.INP_VALID = 2'b00;
        repeat (3) step();
        bus.MODE      = 1'b1;
        bus.CMD       = 4'd9;
        bus.OPB       = 8'd9;
        bus.INP_VALID = 2'b10;
        step();
        bus.INP_VALID = 2'b00;
        bus.CMD       = 4'd0;
        vecs++;
        if ({bus.BUSY, bus.RES_VALID} !== 2'b00) begin
            fails++; $display("FAIL mul_exec: got %b want 00", {bus.BUSY, bus.RES_VALID});
        end
        step();
        vecs++;
        if ({bus.BUSY, bus.RES_VALID} !== 2'b10) begin
            fails++; $display("FAIL mul_busy: got %b want 10", {bus.BUSY, bus.RES_VALID});
        end
        step();
        vecs++;
        if ({bus.BUSY, bus.RES_VALID, bus.RES} !== {2'b01, 16'd60}) begin
            fails++; $display("FAIL mul_res: got %b/%b/%0d want 0/1/60", bus.BUSY, bus.RES_VALID, bus.RES);
        end
    endtask

    task automatic test_timeout();
        bus.OPA       = 8'd7;
        bus.INP_VALID = 2'b01;
        step();
        bus.INP_VALID = 2'b00;
        repeat (TIMEOUT - 1) step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR} !== 2'b00) begin
            fails++; $display("FAIL to_early: got %b want 00", {bus.RES_VALID, bus.ERR});
        end
        step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR, bus.RES} !== {2'b11, 16'd0}) begin
            fails++; $display("FAIL to_fire: got %b/%b/%0h want 1/1/0", bus.RES_VALID, bus.ERR, bus.RES);
        end
        step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR} !== 2'b01) begin
            fails++; $display("FAIL to_hold: got %b want 01", {bus.RES_VALID, bus.ERR});
        end
        issue(1'b1, 4'd8, 8'd3, 8'd3, 1'b0);
        step();
        vecs++;
        if ({bus.G, bus.E, bus.L, bus.ERR, bus.RES} !== {4'b0100, 16'd0}) begin
            fails++; $display("FAIL cmp_eq: got %b/%0h want 0100/0", {bus.G, bus.E, bus.L, bus.ERR}, bus.RES);
        end
    endtask

    task automatic test_logic();
        issue(1'b0, 4'd12, 8'h81, 8'h01, 1'b0);
        step();
        vecs++;
        if ({bus.RES, bus.ERR} !== {16'h0003, 1'b0}) begin
            fails++; $display("FAIL rol: got %0h/%b want 3/0", bus.RES, bus.ERR);
        end
        issue(1'b0, 4'd12, 8'h81, 8'h11, 1'b0);
        step();
        vecs++;
        if ({bus.RES, bus.ERR, bus.RES_VALID} !== {16'h0000, 2'b11}) begin
            fails++; $display("FAIL rol_bad: got %0h/%b/%b want 0/1/1", bus.RES, bus.ERR, bus.RES_VALID);
        end
        issue(1'b0, 4'd13, 8'h81, 8'h01, 1'b0);
        step();
        vecs++;
        if ({bus.RES, bus.ERR} !== {16'h00C0, 1'b0}) begin
            fails++; $display("FAIL ror: got %0h/%b want c0/0", bus.RES, bus.ERR);
        end
        issue(1'b0, 4'd1, 8'hF0, 8'h3C, 1'b0);
        step();
        vecs++;
        if (bus.RES !== 16'h00CF) begin
            fails++; $display("FAIL nand: got %0h want cf", bus.RES);
        end
    endtask

    task automatic test_reset_mul2();
        issue(1'b1, 4'd10, 8'd3, 8'd4, 1'b0);
        step();
        vecs++;
        if ({bus.BUSY, bus.RES} !== {1'b1, 16'h00CF}) begin
            fails++; $display("FAIL rstmul_busy: got %b/%0h want 1/cf", bus.BUSY, bus.RES);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if ({bus.BUSY, bus.RES_VALID, bus.RES} !== 18'd0) begin
            fails++; $display("FAIL rstmul_clear: got %b/%b/%0h want 0/0/0", bus.BUSY, bus.RES_VALID, bus.RES);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++;
            if ({bus.RES_VALID, bus.RES} !== 17'd0) begin
                fails++; $display("FAIL rstmul_novalid: got %b/%0h want 0/0", bus.RES_VALID, bus.RES);
            end
        end
    endtask

    task automatic test_illegal();
        issue(1'b1, 4'd13, 8'd1, 8'd2, 1'b0);
        step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR, bus.RES} !== {2'b11, 16'd0}) begin
            fails++; $display("FAIL ill_arith: got %b/%b/%0h want 1/1/0", bus.RES_VALID, bus.ERR, bus.RES);
        end
        issue(1'b0, 4'd14, 8'd1, 8'd2, 1'b0);
        step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR, bus.RES} !== {2'b11, 16'd0}) begin
            fails++; $display("FAIL ill_logic: got %b/%b/%0h want 1/1/0", bus.RES_VALID, bus.ERR, bus.RES);
        end
    endtask

    task automatic test_ce_freeze();
        issue(1'b1, 4'd0, 8'd1, 8'd2, 1'b0);
        step();
        bus.CE = 1'b0;
        step();
        step();
        vecs++;
        if ({bus.RES_VALID, bus.RES} !== {1'b1, 16'd3}) begin
            fails++; $display("FAIL ce_hold: got %b/%0d want 1/3", bus.RES_VALID, bus.RES);
        end
        bus.CE = 1'b1;
        step();
        vecs++;
        if (bus.RES_VALID !== 1'b0) begin
            fails++; $display("FAIL ce_release: got %b want 0", bus.RES_VALID);
        end
        bus.OPA       = 8'd9;
        bus.INP_VALID = 2'b01;
        step();
        bus.INP_VALID = 2'b00;
        bus.CE        = 1'b0;
        repeat (5) step();
        bus.CE = 1'b1;
        repeat (TIMEOUT - 1) step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR} !== 2'b00) begin
            fails++; $display("FAIL ce_to_early: got %b want 00", {bus.RES_VALID, bus.ERR});
        end
        step();
        vecs++;
        if ({bus.RES_VALID, bus.ERR, bus.RES} !== {2'b11, 16'd0}) begin
            fails++; $display("FAIL ce_to_fire: got %b/%b/%0h want 1/1/0", bus.RES_VALID, bus.ERR, bus.RES);
        end
    endtask

    initial begin
        vecs          = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.CE        = 1'b1;
        bus.MODE      = 1'b0;
        bus.CMD       = '0;
        bus.INP_VALID = 2'b00;
        bus.OPA       = '0;
        bus.OPB       = '0;
        bus.CIN       = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_mul_split();
        test_timeout();
        test_logic();
        test_reset_mul2();
        test_illegal();
        test_ce_freeze();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
